// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding and sizing constants.
package dmem_pkg;

  localparam int WAIT_CNT_W = 4;
  localparam int NUM_LANES  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Core-to-data-memory request/response bundle; the core is the master, the responder the slave.
interface dmem_responder_if;

  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  byteEnable;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
  logic        err;

  modport master (
    output req, we, addr, wdata, byteEnable,
    input  rdata, ready, busy, err
  );

  modport slave (
    input  req, we, addr, wdata, byteEnable,
    output rdata, ready, busy, err
  );

endinterface

// File: rtl/dmem_array.sv
// Unreset word storage built from byte lanes: synchronous per-lane write, combinational word read.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
  input  logic                 clk,
  input  logic [NUM_LANES-1:0] lane_we,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [31:0]          wdata,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic [31:0]          rdata
);

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [7:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
      if (lane_we[l]) begin
        mem[wr_idx] <= wdata[8*l +: 8];
      end
    end

    assign rdata[8*l +: 8] = mem[rd_idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the core's memory stage.
// Define DMEM_RANGE_CHECK_EN to flag out-of-range addresses instead of aliasing them.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  dmem_responder_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
    (WAIT_CYCLES == 0) ? '0 : WAIT_CNT_W'(WAIT_CYCLES - 1);
  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH_WORDS) << 2;

  dmem_state_t           state, next_state;
  logic [WAIT_CNT_W-1:0] cnt, next_cnt;
  logic                  accept;

  logic                  we_q;
  logic [31:0]           addr_q;
  logic [31:0]           wdata_q;
  logic [NUM_LANES-1:0]  be_q;
  logic [31:0]           rdata_q;

  logic                  cur_we;
  logic [31:0]           cur_addr;
  logic                  cur_oor;
  logic                  q_oor;
  logic                  load_rdata;
  logic [NUM_LANES-1:0]  lane_we;
  logic [31:0]           mem_rdata;
  logic                  unused_addr_bits;

  // With zero wait states the read data is captured on the accepting edge,
  // before the request is latched, so the array is addressed from the bus in IDLE.
  assign cur_we   = (state == IDLE) ? bus.we   : we_q;
  assign cur_addr = (state == IDLE) ? bus.addr : addr_q;

`ifdef DMEM_RANGE_CHECK_EN
  assign cur_oor = (cur_addr >= ADDR_LIMIT);
  assign q_oor   = (addr_q >= ADDR_LIMIT);
`else
  assign cur_oor = 1'b0;
  assign q_oor   = 1'b0;
`endif

  assign unused_addr_bits = ^{cur_addr[1:0], addr_q[1:0],
                              cur_addr[31:IDX_W+2], addr_q[31:IDX_W+2], ADDR_LIMIT};

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            next_state = RESP;
          end else begin
            next_state = WAIT;
            next_cnt   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          next_state = RESP;
        end else begin
          next_cnt = cnt - 1'b1;
        end
      end
      RESP: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  assign load_rdata = (next_state == RESP) && (state != RESP) && !cur_we;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      if (accept) begin
        we_q    <= bus.we;
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
        be_q    <= bus.byteEnable;
      end
      if (load_rdata) begin
        rdata_q <= cur_oor ? '0 : mem_rdata;
      end
    end
  end

  // The write lands on the edge that leaves RESP; an async reset drops the
  // state out of RESP first, which is what keeps an aborted write from committing.
  assign lane_we = (state == RESP && we_q && !q_oor) ? be_q : '0;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk     (clk),
    .lane_we (lane_we),
    .wr_idx  (addr_q[IDX_W+1:2]),
    .wdata   (wdata_q),
    .rd_idx  (cur_addr[IDX_W+1:2]),
    .rdata   (mem_rdata)
  );

  assign bus.rdata = rdata_q;
  assign bus.ready = (state == RESP);
  assign bus.busy  = (state != IDLE);
  assign bus.err   = (state == RESP) && q_oor;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: randomized traffic against a word-array model,
// plus directed reset-abort and zero-wait-state throughput scenarios.
module tb_dmem_responder;

  localparam int DEPTH = 64;
  localparam int WAITC = 2;

  typedef struct {
    bit          is_read;
    bit          chk_rdata;
    logic [31:0] rdata;
    bit          err;
    int          accept;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;
  int   checks = 0;
  int   passes = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] last_rdata = '0;
  exp_t        sb[$];
  exp_t        mon_e;

  dmem_responder_if bus ();
  dmem_responder_if bus0 ();

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, got time %0t required < 300000", $time);
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic bit model_oor(input logic [31:0] a);
`ifdef DMEM_RANGE_CHECK_EN
    return (a >= 32'(DEPTH * 4));
`else
    return 1'b0;
`endif
  endfunction

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset && bus.ready) begin
      if (sb.size() == 0) begin
        check_output("spurious_ready", 32'(bus.ready), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check_output("latency", 32'(cyc), 32'(mon_e.accept + WAITC));
        check_output("busy_with_ready", 32'(bus.busy), 32'd1);
        check_output("err", 32'(bus.err), 32'(mon_e.err));
        if (mon_e.chk_rdata)
          check_output(mon_e.is_read ? "read_data" : "rdata_hold", bus.rdata, mon_e.rdata);
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at the negedge after completion.
  task automatic apply_stimulus(input bit w, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] be);
    int   guard;
    int   idx;
    exp_t e;
    guard = 0;
    while (bus.busy && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check_output("idle_timeout", 32'(bus.busy), 32'd0);
    bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d; bus.byteEnable = be;
    @(posedge clk);
    #1;
    idx = int'((a / 32'd4) % 32'(DEPTH));
    e.accept  = cyc;
    e.is_read = !w;
    e.err     = model_oor(a);
    if (!w) begin
      e.rdata     = e.err ? 32'd0 : model_mem[idx];
      e.chk_rdata = 1'b1;
      last_rdata  = e.rdata;
    end else begin
      e.rdata     = last_rdata;
      e.chk_rdata = !e.err;
      if (!e.err)
        for (int b = 0; b < 4; b++)
          if (be[b]) model_mem[idx][8*b +: 8] = d[8*b +: 8];
    end
    sb.push_back(e);
    guard = 0;
    do begin
      bus.req = 1'($urandom); bus.we = 1'($urandom); bus.addr = $urandom;
      bus.wdata = $urandom; bus.byteEnable = 4'($urandom);
      @(negedge clk);
      guard++;
    end while (bus.busy && guard < 50);
    if (guard >= 50) check_output("complete_timeout", 32'(bus.busy), 32'd0);
    bus.req = 1'b0;
  endtask

  task automatic reset_during_wait();
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h20;
    bus.wdata = 32'hFFFF_FFFF; bus.byteEnable = 4'hF;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    #2;
    check_output("pre_reset_busy", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    #1;
    check_output("abort_ready", 32'(bus.ready), 32'd0);
    check_output("abort_busy", 32'(bus.busy), 32'd0);
    check_output("abort_err", 32'(bus.err), 32'd0);
    check_output("abort_rdata", bus.rdata, 32'd0);
    last_rdata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int guard;
    bus.req = 0; bus.we = 0; bus.addr = 0; bus.wdata = 0; bus.byteEnable = 0;
    bus0.req = 0; bus0.we = 0; bus0.addr = 0; bus0.wdata = 0; bus0.byteEnable = 0;
    repeat (3) @(negedge clk);
    check_output("reset_ready", 32'(bus.ready), 32'd0);
    check_output("reset_busy", 32'(bus.busy), 32'd0);
    check_output("reset_err", 32'(bus.err), 32'd0);
    check_output("reset_rdata", bus.rdata, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < DEPTH; i++) apply_stimulus(1'b1, 32'(i * 4), $urandom, 4'hF);

    apply_stimulus(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    apply_stimulus(1'b0, 32'h10, 32'h0, 4'h0);
    apply_stimulus(1'b1, 32'h10, 32'h0000_AA00, 4'b0010);
    apply_stimulus(1'b0, 32'h10, 32'h0, 4'hF);
    apply_stimulus(1'b1, 32'h14, 32'h1111_1111, 4'b0000);
    apply_stimulus(1'b0, 32'h14, 32'h0, 4'h0);
    apply_stimulus(1'b1, 32'h100, 32'hA5A5_A5A5, 4'hF);
    apply_stimulus(1'b0, 32'h0, 32'h0, 4'h0);

    apply_stimulus(1'b1, 32'h20, 32'h1234_5678, 4'hF);
    apply_stimulus(1'b0, 32'h4, 32'h0, 4'h0);
    reset_during_wait();
    apply_stimulus(1'b0, 32'h20, 32'h0, 4'h0);

    repeat (150) begin
      logic [31:0] a;
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = 32'($urandom_range(0, DEPTH * 4 - 1));
      apply_stimulus(1'($urandom), a, $urandom, 4'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check_output("drain_outstanding", 32'(sb.size()), 32'd0);

    // Zero wait states with req held: write then reads, one completion every two cycles.
    bus0.req = 1'b1; bus0.we = 1'b1; bus0.addr = 32'h8;
    bus0.wdata = 32'hCAFE_F00D; bus0.byteEnable = 4'hF;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_output("w0_ready", 32'(bus0.ready), 32'((i % 2) == 0));
      if (i == 0) begin
        bus0.we = 1'b0;
        bus0.wdata = 32'h0;
      end
      if (i >= 2 && bus0.ready) check_output("w0_read_data", bus0.rdata, 32'hCAFE_F00D);
    end
    bus0.req = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
